// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int X_LEN = 32
);
    logic             p0_req_i;
    logic             p0_we_i;
    logic [X_LEN-1:0] p0_addr_i;
    logic [X_LEN-1:0] p0_wdata_i;
    logic             p0_gnt_o;
    logic             p0_rvalid_o;
    logic [X_LEN-1:0] p0_rdata_o;
    logic             p0_err_o;

    logic             p1_req_i;
    logic             p1_we_i;
    logic [X_LEN-1:0] p1_addr_i;
    logic [X_LEN-1:0] p1_wdata_i;
    logic             p1_gnt_o;
    logic             p1_rvalid_o;
    logic [X_LEN-1:0] p1_rdata_o;
    logic             p1_err_o;

    logic             mem_we_o;
    logic [X_LEN-1:0] mem_addr_o;
    logic [X_LEN-1:0] mem_wdata_o;
    logic [X_LEN-1:0] mem_rdata_i;
    logic             busy_o;

    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        input  mem_rdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
        output mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );

    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        output mem_rdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter/sequencer (DMEM_ARB_RR_EN selects round-robin)
module dmem_arbiter #(
    parameter int X_LEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e           state_q, state_d;
    logic             win_q, win_d;
    logic             load;
    logic             we_q;
    logic [X_LEN-1:0] addr_q;
    logic [X_LEN-1:0] wdata_q;
    logic [X_LEN-1:0] rdata_q;
    logic             err_q;
    logic             aligned;
    logic             pick;

    assign aligned = (addr_q[1:0] == 2'b00);

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    // When both ports contend, favour the port that did not win last time
    always_comb begin
        pick = 1'b0;
        if (bus.p0_req_i && bus.p1_req_i) begin
            pick = ~last_q;
        end else begin
            pick = bus.p1_req_i;
        end
    end

    // Last-winner pointer; reset to 1 so port 0 goes first
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else if (load) begin
            last_q <= win_d;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is idle
    always_comb begin
        pick = ~bus.p0_req_i;
    end
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
        end
    end

    // Next state: sample requests only in IDLE, then fixed ACCESS -> RESP -> IDLE walk
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.p0_req_i || bus.p1_req_i) begin
                    load    = 1'b1;
                    win_d   = pick;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request fields; capture the response during ACCESS
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load) begin
                we_q    <= win_d ? bus.p1_we_i    : bus.p0_we_i;
                addr_q  <= win_d ? bus.p1_addr_i  : bus.p0_addr_i;
                wdata_q <= win_d ? bus.p1_wdata_i : bus.p0_wdata_i;
            end
            if (state_q == ACCESS) begin
                rdata_q <= aligned ? bus.mem_rdata_i : '0;
                err_q   <= ~aligned;
            end
        end
    end

    // Outputs decoded only from registered state so no input reaches an output combinationally
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.mem_we_o    = (state_q == ACCESS) && we_q && aligned;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    assign bus.p0_gnt_o    = (state_q == ACCESS) && !win_q;
    assign bus.p1_gnt_o    = (state_q == ACCESS) &&  win_q;
    assign bus.p0_rvalid_o = (state_q == RESP)   && !win_q;
    assign bus.p1_rvalid_o = (state_q == RESP)   &&  win_q;
    assign bus.p0_err_o    = bus.p0_rvalid_o && err_q;
    assign bus.p1_err_o    = bus.p1_rvalid_o && err_q;
    assign bus.p0_rdata_o  = bus.p0_rvalid_o ? rdata_q : '0;
    assign bus.p1_rdata_o  = bus.p1_rvalid_o ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.X_LEN(32)) bus ();

    dmem_arbiter #(.X_LEN(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:63];

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.p0_req_i = 1'b0;
        bus.p1_req_i = 1'b0;
    endtask

    task automatic drive(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            bus.p0_req_i = 1'b1; bus.p0_we_i = we; bus.p0_addr_i = addr; bus.p0_wdata_i = wdata;
        end else begin
            bus.p1_req_i = 1'b1; bus.p1_we_i = we; bus.p1_addr_i = addr; bus.p1_wdata_i = wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v.port, v.we, v.addr, v.wdata);
        @(negedge clk);
        check({tag, " gnt"},     v.port ? bus.p1_gnt_o : bus.p0_gnt_o, 1);
        check({tag, " gnt_oth"}, v.port ? bus.p0_gnt_o : bus.p1_gnt_o, 0);
        check({tag, " mem_addr"}, bus.mem_addr_o, v.addr);
        check({tag, " mem_we"},  bus.mem_we_o, {31'd0, v.we && (v.addr[1:0] == 2'b00)});
        clear_reqs();
        @(negedge clk);
        check({tag, " rvalid"},  v.port ? bus.p1_rvalid_o : bus.p0_rvalid_o, 1);
        check({tag, " rvalid_oth"}, v.port ? bus.p0_rvalid_o : bus.p1_rvalid_o, 0);
        check({tag, " rdata"},   v.port ? bus.p1_rdata_o : bus.p0_rdata_o, v.exp_rdata);
        check({tag, " err"},     v.port ? bus.p1_err_o : bus.p0_err_o, {31'd0, v.exp_err});
        check({tag, " we_resp"}, bus.mem_we_o, 0);
        @(negedge clk);
        check({tag, " idle"},    bus.busy_o, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h28, 32'h0,        32'h0000000A, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'hA5000010, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h42, 32'h0,        32'h00000000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h43, 32'h12345678, 32'h00000000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 32'hA5000011, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h44, 32'h0,        32'hCAFEF00D, 1'b0};

        for (int i = 0; i < 64; i++) mem[i] <= 32'hA5000000 | i;
        mem[10] <= 32'h0000000A;

        bus.p0_req_i = 0; bus.p0_we_i = 0; bus.p0_addr_i = 0; bus.p0_wdata_i = 0;
        bus.p1_req_i = 0; bus.p1_we_i = 0; bus.p1_addr_i = 0; bus.p1_wdata_i = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst p0_gnt", bus.p0_gnt_o, 0);
        check("rst p1_gnt", bus.p1_gnt_o, 0);
        check("rst p0_rvalid", bus.p0_rvalid_o, 0);
        check("rst p1_rvalid", bus.p1_rvalid_o, 0);
        check("rst mem_we", bus.mem_we_o, 0);
        check("rst mem_addr", bus.mem_addr_o, 0);
        check("rst mem_wdata", bus.mem_wdata_o, 0);
        check("rst busy", bus.busy_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // p1 raises req while p0 is in RESP
        drive(1'b0, 1'b0, 32'h28, 32'h0);
        @(negedge clk);
        check("late p0_gnt", bus.p0_gnt_o, 1);
        clear_reqs();
        @(negedge clk);
        check("late p0_rvalid", bus.p0_rvalid_o, 1);
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("late idle_gnt", bus.p1_gnt_o, 0);
        check("late idle_busy", bus.busy_o, 0);
        @(negedge clk);
        check("late p1_gnt", bus.p1_gnt_o, 1);
        clear_reqs();
        @(negedge clk);
        check("late p1_rvalid", bus.p1_rvalid_o, 1);
        check("late p1_rdata", bus.p1_rdata_o, 32'hDEADBEEF);
        @(negedge clk);

        // Reset during ACCESS of a write
        drive(1'b0, 1'b1, 32'h48, 32'h55555555);
        @(negedge clk);
        check("abort gnt", bus.p0_gnt_o, 1);
        check("abort we_pre", bus.mem_we_o, 1);
        rst_n = 1'b0;
        clear_reqs();
        #1;
        check("abort we", bus.mem_we_o, 0);
        check("abort gnt_rst", bus.p0_gnt_o, 0);
        check("abort busy", bus.busy_o, 0);
        check("abort addr", bus.mem_addr_o, 0);
        @(negedge clk);
        check("abort rvalid", bus.p0_rvalid_o, 0);
        check("abort mem", mem[18], 32'hA5000012);
        drive(1'b0, 1'b0, 32'h28, 32'h0);
        drive(1'b1, 1'b0, 32'h44, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst p0_gnt", bus.p0_gnt_o, 1);
        check("post_rst p1_gnt", bus.p1_gnt_o, 0);
        clear_reqs();
        @(negedge clk);
        check("post_rst rdata", bus.p0_rdata_o, 32'h0000000A);
        @(negedge clk);

        // Both ports hold req continuously from reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h28, 32'h0);
        drive(1'b1, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic e0, e1;
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            e0 = (k % 3 == 1) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 1) && ((k / 3) % 2 == 1);
`else
            e0 = (k % 3 == 1);
            e1 = 1'b0;
`endif
            check($sformatf("arb c%0d p0_gnt", k), {31'd0, bus.p0_gnt_o}, {31'd0, e0});
            check($sformatf("arb c%0d p1_gnt", k), {31'd0, bus.p1_gnt_o}, {31'd0, e1});
        end
        clear_reqs();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
